// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the multiply/divide engine: op codes, FSM states, step count.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } mdu_state_e;

  localparam int unsigned MDU_STEPS = 32;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift {rem,quo} left by one, subtract the divisor when it fits.
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    if (shifted >= {1'b0, divisor}) begin
      // the true difference is below the divisor, so it always fits in WIDTH bits
      rem_next = shifted[WIDTH-1:0] - divisor;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine producing HI/LO with a one-cycle write strobe.
// Define MDU_FAST_MULT_EN to compute multiplies with a single combinational multiplier.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             hilo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(MDU_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_STEPS - 1);

  mdu_state_e       state_r, state_n;
  mdu_op_e          op_in;
  logic             is_mul_in, signed_in, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] ld_hi, ld_lo, ld_opd;
  logic             ld_neg_res, ld_neg_rem, ld_direct;

  logic [WIDTH-1:0] hi_r, lo_r, opd_r, hi_hold, lo_hold;
  logic             is_mul_r, neg_res_r, neg_rem_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  always_comb begin
    op_in     = mdu_op_e'(op_i);
    is_mul_in = (op_in == OP_MULT) || (op_in == OP_MULTU);
    signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
    a_mag     = (signed_in && opa_i[WIDTH-1]) ? -opa_i : opa_i;
    b_mag     = (signed_in && opb_i[WIDTH-1]) ? -opb_i : opb_i;
    accept    = (state_r == ST_IDLE) && start_i && !flush_i;
  end

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

  // Operand load: multiply keeps |a| as addend and shifts |b| through LO;
  // divide shifts |a| through LO with HI as partial remainder.
  always_comb begin
    ld_opd     = is_mul_in ? a_mag : b_mag;
    ld_hi      = '0;
    ld_lo      = is_mul_in ? b_mag : a_mag;
    ld_neg_res = signed_in && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
    ld_neg_rem = signed_in && !is_mul_in && opa_i[WIDTH-1];
    ld_direct  = 1'b0;
    if (!is_mul_in && (opb_i == '0)) begin
      ld_hi      = opa_i;
      ld_lo      = '1;
      ld_neg_res = 1'b0;
      ld_neg_rem = 1'b0;
      ld_direct  = 1'b1;
    end
`ifdef MDU_FAST_MULT_EN
    if (is_mul_in) begin
      {ld_hi, ld_lo} = fast_prod;
      ld_direct      = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_n;
  end

  always_comb begin
    state_n   = state_r;
    stall_o   = 1'b0;
    hilo_we_o = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          state_n = ld_direct ? ST_FINISH : ST_CALC;
        end
      end
      ST_CALC: begin
        stall_o = 1'b1;
        if (cnt_r == CNT_LAST) state_n = ST_FINISH;
      end
      ST_FINISH: begin
        hilo_we_o = 1'b1;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (flush_i) begin
      state_n   = ST_IDLE;
      stall_o   = 1'b0;
      hilo_we_o = 1'b0;
    end
    if (rst) begin
      stall_o   = 1'b0;
      hilo_we_o = 1'b0;
    end
  end

  assign busy_o = (state_r != ST_IDLE);

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (hi_r),
    .quo      (lo_r),
    .divisor  (opd_r),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

  assign mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd_r} : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r      <= '0;
      lo_r      <= '0;
      opd_r     <= '0;
      cnt_r     <= '0;
      is_mul_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      hi_hold   <= '0;
      lo_hold   <= '0;
    end else begin
      if (accept) begin
        hi_r      <= ld_hi;
        lo_r      <= ld_lo;
        opd_r     <= ld_opd;
        cnt_r     <= '0;
        is_mul_r  <= is_mul_in;
        neg_res_r <= ld_neg_res;
        neg_rem_r <= ld_neg_rem;
      end else if (state_r == ST_CALC) begin
        cnt_r <= cnt_r + CNT_W'(1);
        if (is_mul_r) {hi_r, lo_r} <= {mul_sum, lo_r[WIDTH-1:1]};
        else          {hi_r, lo_r} <= {div_rem, div_quo};
      end
      if (hilo_we_o) begin
        hi_hold <= hi_fix;
        lo_hold <= lo_fix;
      end
    end
  end

  always_comb begin
    prod_fix = neg_res_r ? -{hi_r, lo_r} : {hi_r, lo_r};
    if (is_mul_r) begin
      {hi_fix, lo_fix} = prod_fix;
    end else begin
      hi_fix = neg_rem_r ? -hi_r : hi_r;
      lo_fix = neg_res_r ? -lo_r : lo_r;
    end
  end

  assign hi_o = hilo_we_o ? hi_fix : hi_hold;
  assign lo_o = hilo_we_o ? lo_fix : lo_hold;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: result values, write latency, stall, flush, reset.
module tb_mul_div_unit;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;
`ifdef MDU_FAST_MULT_EN
  localparam int unsigned MUL_LAT = 1;
`else
  localparam int unsigned MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i;
  logic [1:0]  op_i;
  logic [31:0] opa_i, opb_i;
  logic        stall_o, busy_o, hilo_we_o;
  logic [31:0] hi_o, lo_o;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .opa_i     (opa_i),
    .opb_i     (opb_i),
    .flush_i   (flush_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .hilo_we_o (hilo_we_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (case %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Called at a negedge while the engine is idle; returns one cycle after the strobe.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int unsigned lat, output logic [31:0] hi, output logic [31:0] lo,
                       output logic ok);
    ok = 1'b1;
    lat = 0;
    hi = 'x;
    lo = 'x;
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
    #1;
    if (stall_o !== 1'b1) ok = 1'b0;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (hilo_we_o === 1'b1) begin
        lat = n; hi = hi_o; lo = lo_o;
        if (stall_o !== 1'b0) ok = 1'b0;
        break;
      end
      if (stall_o !== 1'b1) ok = 1'b0;
    end
    @(negedge clk);
    if (hilo_we_o !== 1'b0 || busy_o !== 1'b0) ok = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat, cnt, we_n;
    logic [31:0] hi, lo, whi, wlo;
    logic        ok;

    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33};
    vecs[4]  = '{DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1};
    vecs[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[6]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[7]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT};
    vecs[8]  = '{DIV,   32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[9]  = '{DIV,   32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1};
    vecs[10] = '{MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, MUL_LAT};
    vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
    vecs[12] = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MUL_LAT};
    vecs[13] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33};
    vecs[14] = '{DIVU,  32'd5,        32'd9,        32'h00000005, 32'h00000000, 33};
    vecs[15] = '{MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, MUL_LAT};
    vecs[16] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, MUL_LAT};
    vecs[17] = '{DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33};

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; opa_i = '0; opb_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_stall", -1, 32'(stall_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", -1, 32'(busy_o), 32'd0);
    chk("rst_we",   -1, 32'(hilo_we_o), 32'd0);
    chk("rst_hi",   -1, hi_o, 32'd0);
    chk("rst_lo",   -1, lo_o, 32'd0);

    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, hi, lo, ok);
      chk("latency", i, lat, vecs[i].lat);
      chk("hi", i, hi, vecs[i].hi);
      chk("lo", i, lo, vecs[i].lo);
      chk("stall_we_shape", i, 32'(ok), 32'd1);
      chk("hold_hi", i, hi_o, vecs[i].hi);
    end

    // Flush at T+10 of a divide, then restart at T+11.
    start_i = 1'b1; op_i = DIV; opa_i = 32'd100; opb_i = 32'd7;
    @(posedge clk);
    #1 start_i = 1'b0;
    we_n = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (hilo_we_o === 1'b1) we_n++;
    end
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush_stall", 100, 32'(stall_o), 32'd0);
    if (hilo_we_o === 1'b1) we_n++;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    chk("flush_idle", 100, 32'(busy_o), 32'd0);
    chk("flush_no_we", 100, we_n, 32'd0);
    do_op(DIVU, 32'd100, 32'd7, lat, hi, lo, ok);
    chk("post_flush_lat", 101, lat, 32'd33);
    chk("post_flush_hi", 101, hi, 32'h2);
    chk("post_flush_lo", 101, lo, 32'hE);
    chk("post_flush_shape", 101, 32'(ok), 32'd1);

    // start_i pulsed while busy must be ignored.
    start_i = 1'b1; op_i = DIVU; opa_i = 32'hFFFFFFFF; opb_i = 32'h10;
    @(posedge clk);
    #1 start_i = 1'b0;
    cnt = 0; we_n = 0; whi = '0; wlo = '0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (hilo_we_o === 1'b1) begin
        cnt++; we_n = n; whi = hi_o; wlo = lo_o;
      end
      if (n == 5) begin
        start_i = 1'b1; op_i = MULTU; opa_i = 32'd3; opb_i = 32'd3;
      end else if (n == 6) begin
        start_i = 1'b0;
      end
    end
    chk("busy_we_count", 102, cnt, 32'd1);
    chk("busy_we_cycle", 102, we_n, 32'd33);
    chk("busy_hi", 102, whi, 32'hF);
    chk("busy_lo", 102, wlo, 32'h0FFFFFFF);

    // Reset at T+20 of a divide.
    start_i = 1'b1; op_i = DIV; opa_i = 32'hFFFFFFF9; opb_i = 32'd2;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int n = 1; n <= 19; n++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_stall", 103, 32'(stall_o), 32'd0);
    chk("midrst_we", 103, 32'(hilo_we_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 103, 32'(busy_o), 32'd0);
    chk("midrst_hi", 103, hi_o, 32'd0);
    chk("midrst_lo", 103, lo_o, 32'd0);
    cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (hilo_we_o === 1'b1) cnt++;
    end
    chk("midrst_no_we", 103, cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
